// File: rtl/quant_zigzag_mcu.sv
// Quantiser + zig-zag reorderer with ping-pong banks for the MJPEG encoder.
// Define QUANT_ROUND_EN for round-half-up quantisation (default: floor).
module quant_zigzag_mcu #(
  parameter int DATA_W  = 12,
  parameter int RECIP_W = 16,
  parameter int OUT_W   = 12
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [1:0]         mode,
  input  logic               din_valid,
  input  logic [DATA_W-1:0]  din,
  output logic               din_ready,
  input  logic               tbl_wr_en,
  input  logic               tbl_wr_sel,
  input  logic [5:0]         tbl_wr_addr,
  input  logic [RECIP_W-1:0] tbl_wr_data,
  output logic               dout_valid,
  output logic [OUT_W-1:0]   dout,
  input  logic               dout_ready,
  output logic [1:0]         dout_comp,
  output logic               dout_sob,
  output logic               dout_eob,
  output logic               dout_eomcu
);

  localparam int PW = DATA_W + RECIP_W + 1;

  localparam logic signed [PW-1:0] QMAX = PW'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [PW-1:0] QMIN = ~QMAX;

  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    DRAINING
  } bank_st_t;

  bank_st_t bank_st_q [2];
  bank_st_t bank_st_d [2];

  logic [5:0] k_q;
  logic [2:0] b_q;
  logic [1:0] mode_q;
  logic [1:0] mode_eff;
  logic [1:0] comp_in;
  logic       last_blk;
  logic       wptr_q;
  logic       rptr_q;
  logic       acc;

  logic [1:0] bank_comp_q  [2];
  logic       bank_eomcu_q [2];

  logic [RECIP_W-1:0] tbl_y [64];
  logic [RECIP_W-1:0] tbl_c [64];

  logic                     s1_v;
  logic                     s1_bank;
  logic [5:0]               s1_k;
  logic signed [DATA_W-1:0] s1_din;
  logic [RECIP_W-1:0]       s1_recip;

  logic                 s2_v;
  logic                 s2_bank;
  logic [5:0]           s2_k;
  logic signed [PW-1:0] s2_prod;

  logic signed [PW-1:0] q_full;
  logic [OUT_W-1:0]     q_sat;

  logic [OUT_W-1:0] mem [128];

  logic [5:0] j_q;
  logic       ld_ok;
  logic       rd_go;
  logic       rd_last;

  assign acc = din_valid & din_ready;

  assign din_ready = (bank_st_q[wptr_q] == EMPTY) ||
                     (bank_st_q[wptr_q] == FILLING);

  // mode is only sampled on the first coefficient of an MCU
  assign mode_eff = (k_q == 6'd0 && b_q == 3'd0) ? mode : mode_q;

  always_comb begin
    comp_in  = 2'd0;
    last_blk = 1'b0;
    unique case (mode_eff)
      2'd0: begin
        comp_in  = (b_q < 3'd4) ? 2'd0 : 2'(b_q - 3'd3);
        last_blk = (b_q == 3'd5);
      end
      2'd1: begin
        comp_in  = (b_q < 3'd2) ? 2'd0 : 2'(b_q - 3'd1);
        last_blk = (b_q == 3'd3);
      end
      2'd2: begin
        comp_in  = 2'(b_q);
        last_blk = (b_q == 3'd2);
      end
      default: begin
        comp_in  = 2'd0;
        last_blk = 1'b1;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      k_q             <= 6'd0;
      b_q             <= 3'd0;
      mode_q          <= 2'd0;
      wptr_q          <= 1'b0;
      bank_comp_q[0]  <= 2'd0;
      bank_comp_q[1]  <= 2'd0;
      bank_eomcu_q[0] <= 1'b0;
      bank_eomcu_q[1] <= 1'b0;
    end else if (acc) begin
      k_q <= k_q + 6'd1;
      if (k_q == 6'd0) begin
        bank_comp_q[wptr_q]  <= comp_in;
        bank_eomcu_q[wptr_q] <= last_blk;
        if (b_q == 3'd0) mode_q <= mode;
      end
      if (k_q == 6'd63) begin
        wptr_q <= ~wptr_q;
        b_q    <= last_blk ? 3'd0 : b_q + 3'd1;
      end
    end
  end

  // tables keep their contents across reset
  always_ff @(posedge sys_clk) begin
    if (tbl_wr_en) begin
      if (tbl_wr_sel) tbl_c[tbl_wr_addr] <= tbl_wr_data;
      else            tbl_y[tbl_wr_addr] <= tbl_wr_data;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      s1_v <= acc;
      s2_v <= s1_v;
    end
  end

  always_ff @(posedge sys_clk) begin
    s1_recip <= (comp_in == 2'd0) ? tbl_y[k_q] : tbl_c[k_q];
    s1_din   <= $signed(din);
    s1_k     <= k_q;
    s1_bank  <= wptr_q;
    s2_prod  <= PW'(s1_din) * PW'($signed({1'b0, s1_recip}));
    s2_k     <= s1_k;
    s2_bank  <= s1_bank;
  end

`ifdef QUANT_ROUND_EN
  localparam logic signed [PW-1:0] HALF = PW'(2 ** (RECIP_W - 1));
  assign q_full = (s2_prod + HALF) >>> RECIP_W;
`else
  assign q_full = s2_prod >>> RECIP_W;
`endif

  always_comb begin
    if (q_full > QMAX)      q_sat = QMAX[OUT_W-1:0];
    else if (q_full < QMIN) q_sat = QMIN[OUT_W-1:0];
    else                    q_sat = q_full[OUT_W-1:0];
  end

  always_ff @(posedge sys_clk) begin
    if (s2_v) mem[{s2_bank, s2_k}] <= q_sat;
  end

  assign ld_ok   = ~dout_valid | dout_ready;
  assign rd_go   = ld_ok & ((bank_st_q[rptr_q] == FULL) ||
                            (bank_st_q[rptr_q] == DRAINING));
  assign rd_last = rd_go & (j_q == 6'd63);

  // drain-complete is applied first so a refill start can override it
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      bank_st_d[i] = bank_st_q[i];
      if (rd_go && rptr_q == 1'(i))
        bank_st_d[i] = rd_last ? EMPTY : DRAINING;
      if (acc && k_q == 6'd0 && wptr_q == 1'(i))
        bank_st_d[i] = FILLING;
      if (s2_v && s2_k == 6'd63 && s2_bank == 1'(i))
        bank_st_d[i] = FULL;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      bank_st_q[0] <= EMPTY;
      bank_st_q[1] <= EMPTY;
    end else begin
      bank_st_q <= bank_st_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      dout_valid <= 1'b0;
      dout       <= '0;
      dout_comp  <= 2'd0;
      dout_sob   <= 1'b0;
      dout_eob   <= 1'b0;
      dout_eomcu <= 1'b0;
      j_q        <= 6'd0;
      rptr_q     <= 1'b0;
    end else if (rd_go) begin
      dout_valid <= 1'b1;
      dout       <= mem[{rptr_q, ZZ[j_q]}];
      dout_comp  <= bank_comp_q[rptr_q];
      dout_sob   <= (j_q == 6'd0);
      dout_eob   <= (j_q == 6'd63);
      dout_eomcu <= (j_q == 6'd63) & bank_eomcu_q[rptr_q];
      j_q        <= j_q + 6'd1;
      if (j_q == 6'd63) rptr_q <= ~rptr_q;
    end else if (dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_quant_zigzag_mcu.sv
// Bench for quant_zigzag_mcu: block-level reference model with scoreboard,
// directed scenarios, a narrow-output instance and randomized traffic.
module tb_quant_zigzag_mcu;
  localparam int DW = 12;
  localparam int RW = 16;
  localparam int OW = 12;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic          din_valid = 1'b0;
  logic [DW-1:0] din = '0;
  logic          din_ready;
  logic          tbl_wr_en = 1'b0;
  logic          tbl_wr_sel = 1'b0;
  logic [5:0]    tbl_wr_addr = '0;
  logic [RW-1:0] tbl_wr_data = '0;
  logic          dout_valid;
  logic [OW-1:0] dout;
  logic          dout_ready = 1'b1;
  logic [1:0]    dout_comp;
  logic          dout_sob, dout_eob, dout_eomcu;

  logic [1:0]    d8_mode = 2'd3;
  logic          d8_din_valid = 1'b0;
  logic [DW-1:0] d8_din = '0;
  logic          d8_din_ready;
  logic          d8_tbl_wr_en = 1'b0;
  logic [5:0]    d8_tbl_wr_addr = '0;
  logic          d8_dout_valid;
  logic [7:0]    d8_dout;
  logic          d8_dout_ready = 1'b1;
  logic [1:0]    d8_dout_comp;
  logic          d8_sob, d8_eob, d8_eomcu;

  always #5 sys_clk = ~sys_clk;

  quant_zigzag_mcu dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .mode(mode),
    .din_valid(din_valid), .din(din), .din_ready(din_ready),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_sel(tbl_wr_sel),
    .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data),
    .dout_valid(dout_valid), .dout(dout), .dout_ready(dout_ready),
    .dout_comp(dout_comp), .dout_sob(dout_sob), .dout_eob(dout_eob),
    .dout_eomcu(dout_eomcu)
  );

  quant_zigzag_mcu #(.OUT_W(8)) dut8 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .mode(d8_mode),
    .din_valid(d8_din_valid), .din(d8_din), .din_ready(d8_din_ready),
    .tbl_wr_en(d8_tbl_wr_en), .tbl_wr_sel(1'b0),
    .tbl_wr_addr(d8_tbl_wr_addr), .tbl_wr_data(16'hFFFF),
    .dout_valid(d8_dout_valid), .dout(d8_dout), .dout_ready(d8_dout_ready),
    .dout_comp(d8_dout_comp), .dout_sob(d8_sob), .dout_eob(d8_eob),
    .dout_eomcu(d8_eomcu)
  );

  typedef struct {
    int val; int comp; bit sob; bit eob; bit eomcu; longint cyc;
  } rec_t;

  rec_t   expq[$];
  rec_t   olog[$];
  int     d8log[$];
  int     d8_in[$];
  int     d8_acc = 0;
  int     n_chk = 0;
  int     n_fail = 0;
  longint cyc = 0;
  longint acc63_cyc = -1;
  int     zz[64];
  int     mtbl[2][64];
  int     mk = 0, mb = 0, mmode = 0, bcomp = 0;
  bit     blast = 0;
  int     bdin[64], brc[64];
  bit     rand_rdy = 0;
  bit     prev_stall = 0;
  int     pv_val = 0, pv_comp = 0;
  logic [2:0] pv_tags = '0;

  task automatic chk(input bit ok, input string nm,
                     input longint act, input longint req);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  function automatic int quant(input int d, input int r, input int ow);
    longint p, q, hi, lo;
    p = longint'(d) * longint'(r);
`ifdef QUANT_ROUND_EN
    q = (p + (longint'(1) <<< (RW - 1))) >>> RW;
`else
    q = p >>> RW;
`endif
    hi = (longint'(1) <<< (ow - 1)) - 1;
    lo = -hi - 1;
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    return int'(q);
  endfunction

  function automatic int comp_of(input int md, input int b);
    case (md)
      0: return (b < 4) ? 0 : b - 3;
      1: return (b < 2) ? 0 : b - 1;
      2: return b;
      default: return 0;
    endcase
  endfunction

  function automatic int nblk(input int md);
    case (md)
      0: return 6;
      1: return 4;
      2: return 3;
      default: return 1;
    endcase
  endfunction

  // whole-block model: collect 64 raster inputs, emit in zig-zag order
  task automatic model_accept(input int v);
    rec_t e;
    if (mk == 0) begin
      if (mb == 0) mmode = int'(mode);
      bcomp = comp_of(mmode, mb);
      blast = (mb == nblk(mmode) - 1);
    end
    bdin[mk] = v;
    brc[mk]  = mtbl[(bcomp == 0) ? 0 : 1][mk];
    if (mk == 63) begin
      acc63_cyc = cyc;
      for (int i = 0; i < 64; i++) begin
        e.val   = quant(bdin[zz[i]], brc[zz[i]], OW);
        e.comp  = bcomp;
        e.sob   = (i == 0);
        e.eob   = (i == 63);
        e.eomcu = (i == 63) && blast;
        e.cyc   = 0;
        expq.push_back(e);
      end
      mk = 0;
      mb = blast ? 0 : mb + 1;
    end else begin
      mk++;
    end
  endtask

  initial forever begin
    @(posedge sys_clk);
    cyc++;
  end

  initial forever begin
    @(posedge sys_clk);
    #1;
    if (rand_rdy) dout_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin : monitor
    int dv;
    rec_t e, o;
    bit ok;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_n) begin
        mk = 0; mb = 0; expq.delete(); prev_stall = 0;
      end else begin
        if (din_valid && din_ready) model_accept(int'($signed(din)));
        if (tbl_wr_en) mtbl[tbl_wr_sel][tbl_wr_addr] = int'(tbl_wr_data);
        dv = int'($signed(dout));
        if (prev_stall) begin
          ok = dout_valid && dv == pv_val && int'(dout_comp) == pv_comp &&
               {dout_sob, dout_eob, dout_eomcu} == pv_tags;
          chk(ok, "hold_while_stalled", dv, pv_val);
        end
        if (dout_valid && dout_ready) begin
          o.val = dv; o.comp = int'(dout_comp); o.sob = dout_sob;
          o.eob = dout_eob; o.eomcu = dout_eomcu; o.cyc = cyc;
          olog.push_back(o);
          n_chk++;
          if (expq.size() == 0) begin
            n_fail++;
            $display("FAIL out: unexpected value %0d, none required", dv);
          end else begin
            e = expq.pop_front();
            ok = o.val == e.val && o.comp == e.comp && o.sob == e.sob &&
                 o.eob == e.eob && o.eomcu == e.eomcu;
            if (!ok) begin
              n_fail++;
              $display("FAIL out[%0d]: got v=%0d c=%0d tags=%0b%0b%0b, required v=%0d c=%0d tags=%0b%0b%0b",
                       olog.size() - 1, o.val, o.comp, o.sob, o.eob, o.eomcu,
                       e.val, e.comp, e.sob, e.eob, e.eomcu);
            end
          end
        end
        prev_stall = dout_valid && !dout_ready;
        pv_val  = dv;
        pv_comp = int'(dout_comp);
        pv_tags = {dout_sob, dout_eob, dout_eomcu};
        if (d8_din_valid && d8_din_ready) begin
          d8_acc++;
          d8_in.push_back(int'($signed(d8_din)));
        end
        if (d8_dout_valid && d8_dout_ready)
          d8log.push_back(int'($signed(d8_dout)));
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send(input int v, input int md);
    int n;
    n = 0;
    din = v[DW-1:0];
    mode = md[1:0];
    din_valid = 1'b1;
    @(negedge sys_clk);
    while (!din_ready && n < 500) begin
      n++;
      @(negedge sys_clk);
    end
    if (!din_ready) chk(1'b0, "din_ready_timeout", 0, 1);
    @(posedge sys_clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic fill(input bit sel, input bit rnd, input int val);
    for (int a = 0; a < 64; a++) begin
      tbl_wr_en = 1'b1;
      tbl_wr_sel = sel;
      tbl_wr_addr = 6'(a);
      tbl_wr_data = rnd ? RW'($urandom_range(1, 65535)) : RW'(val);
      tick();
    end
    tbl_wr_en = 1'b0;
    tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expq.size() != 0 || dout_valid) && n < 5000) begin
      n++;
      @(negedge sys_clk);
    end
    if (n >= 5000) chk(1'b0, "drain_timeout", expq.size(), 0);
    tick();
  endtask

  task automatic lit(input string nm, input int idx, input int req);
    if (idx < olog.size()) chk(olog[idx].val == req, nm, olog[idx].val, req);
    else chk(1'b0, nm, -99999, req);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk(!dout_valid && dout == '0 && dout_comp == 2'd0 &&
        !dout_sob && !dout_eob && !dout_eomcu, nm,
        {dout_valid, dout_sob, dout_eob, dout_eomcu}, 0);
    chk(din_ready == 1'b1, {nm, "_din_ready"}, din_ready, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n, r, c, bad, cnt, pos, v, rc, rv, idx;
    int exp8[8];
    n = 0;
    for (int s = 0; s < 15; s++) begin
      for (int t = 0; t < 8; t++) begin
        r = (s % 2 == 1) ? t : 7 - t;
        c = s - r;
        if (c >= 0 && c < 8) begin
          zz[n] = r * 8 + c;
          n++;
        end
      end
    end

    repeat (3) tick();
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    chk_reset_outputs("reset");
    tick();

    // ordering and latency, grey mode
    fill(1'b0, 1'b0, 32768);
    olog.delete();
    for (int k = 0; k < 64; k++) send(k, 3);
    drain();
    chk(olog.size() == 64, "s1_count", olog.size(), 64);
    exp8 = '{0, 0, 4, 8, 4, 1, 1, 5};
    for (int i = 0; i < 8; i++) lit($sformatf("s1_val%0d", i), i, exp8[i]);
    if (olog.size() >= 64) begin
      chk(olog[0].sob && !olog[0].eob, "s1_sob", olog[0].sob, 1);
      chk(olog[63].eob && olog[63].eomcu, "s1_eob_eomcu",
          {olog[63].eob, olog[63].eomcu}, 3);
      chk(olog[0].cyc - acc63_cyc == 4, "s1_latency",
          olog[0].cyc - acc63_cyc, 4);
    end else begin
      chk(1'b0, "s1_tags", olog.size(), 64);
    end

    // rounding
    olog.delete();
    send(-3, 3);
    send(5, 3);
    for (int k = 2; k < 64; k++) send(int'($urandom_range(0, 4095)) - 2048, 3);
    drain();
`ifdef QUANT_ROUND_EN
    lit("s2_neg3", 0, -1);
    lit("s2_pos5", 1, 3);
`else
    lit("s2_neg3", 0, -2);
    lit("s2_pos5", 1, 2);
`endif

    // saturation on the 8-bit instance
    for (int a = 0; a < 64; a++) begin
      d8_tbl_wr_en = 1'b1;
      d8_tbl_wr_addr = 6'(a);
      tick();
    end
    d8_tbl_wr_en = 1'b0;
    tick();
    for (int k = 0; k < 64; k++) begin
      v = (k == 0) ? 2047 : (k == 1) ? -2048 :
          int'($urandom_range(0, 4095)) - 2048;
      d8_din = v[DW-1:0];
      d8_din_valid = 1'b1;
      tick();
    end
    d8_din_valid = 1'b0;
    repeat (80) tick();
    chk(d8_acc == 64, "s3_accepted", d8_acc, 64);
    chk(d8log.size() == 64, "s3_count", d8log.size(), 64);
    if (d8log.size() >= 2) begin
      chk(d8log[0] == 127, "s3_pos_sat", d8log[0], 127);
      chk(d8log[1] == -128, "s3_neg_sat", d8log[1], -128);
    end
    bad = 0;
    for (int i = 0; i < 64; i++)
      if (i >= d8log.size() || zz[i] >= d8_in.size() ||
          d8log[i] != quant(d8_in[zz[i]], 65535, 8)) bad++;
    chk(bad == 0, "s3_block", bad, 0);

    // 4:2:0 MCU
    fill(1'b1, 1'b0, 16384);
    olog.delete();
    for (int k = 0; k < 384; k++) send(64, 0);
    drain();
    chk(olog.size() == 384, "s4_count", olog.size(), 384);
    for (int bi = 0; bi < 6; bi++) begin
      bad = 0;
      rc = (bi < 4) ? 0 : bi - 3;
      rv = (bi < 4) ? 32 : 16;
      for (int i = 0; i < 64; i++) begin
        idx = bi * 64 + i;
        if (idx >= olog.size() || olog[idx].val != rv || olog[idx].comp != rc)
          bad++;
      end
      chk(bad == 0, $sformatf("s4_block%0d", bi), bad, 0);
    end
    cnt = 0;
    pos = -1;
    foreach (olog[i]) if (olog[i].eomcu) begin cnt++; pos = i; end
    chk(cnt == 1 && pos == 383, "s4_eomcu", pos, 383);

    // backpressure
    dout_ready = 1'b0;
    olog.delete();
    for (int k = 0; k < 128; k++) send(int'($urandom_range(0, 4095)) - 2048, 3);
    v = int'($urandom_range(0, 4095)) - 2048;
    din = v[DW-1:0];
    din_valid = 1'b1;
    @(negedge sys_clk);
    chk(din_ready == 1'b0, "s5_ready_low", din_ready, 0);
    repeat (20) @(negedge sys_clk);
    chk(din_ready == 1'b0 && dout_valid, "s5_ready_still_low", din_ready, 0);
    tick();
    dout_ready = 1'b1;
    send(v, 3);
    for (int k = 1; k < 64; k++) send(int'($urandom_range(0, 4095)) - 2048, 3);
    drain();
    chk(olog.size() == 192, "s5_count", olog.size(), 192);

    // reset mid-block
    for (int k = 0; k < 30; k++) send(int'($urandom_range(0, 4095)) - 2048, 3);
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    chk_reset_outputs("s6_reset");
    tick();
    olog.delete();
    for (int k = 0; k < 64; k++) send(int'($urandom_range(0, 4095)) - 2048, 3);
    drain();
    chk(olog.size() == 64, "s6_count", olog.size(), 64);

    // randomized traffic: random tables, modes, gaps and backpressure
    fill(1'b0, 1'b1, 0);
    fill(1'b1, 1'b1, 0);
    olog.delete();
    rand_rdy = 1'b1;
    for (int k = 0; k < 2304; k++) begin
      if ($urandom_range(0, 5) == 0) repeat ($urandom_range(1, 3)) tick();
      case ($urandom_range(0, 9))
        0: v = 2047;
        1: v = -2048;
        default: v = int'($urandom_range(0, 4095)) - 2048;
      endcase
      send(v, int'($urandom_range(0, 3)));
    end
    rand_rdy = 1'b0;
    tick();
    dout_ready = 1'b1;
    drain();
    chk(olog.size() >= 64, "rand_activity", olog.size(), 64);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/quant_zigzag_mcu.md
# quant_zigzag_mcu

Parametrised quantiser and zig-zag reorderer for the MJPEG encoder datapath, placed between the 2-D DCT and the entropy coder. It accepts DCT coefficients in raster order with valid/ready flow control. Each coefficient is multiplied by a runtime-loadable reciprocal from a luma or chroma table, selected by an MCU layout mode. Results go into a 2-bank ping-pong buffer and are emitted in zig-zag order, tagged with component and block/MCU boundary flags.

## Interface
- DATA_W, 12: signed input coefficient width.
- RECIP_W, 16: unsigned reciprocal width; reciprocal = round(2^RECIP_W / Q).
- OUT_W, 12: signed output width; OUT_W <= DATA_W+1.
- sys_clk  in  1  clock, rising edge.
- sys_rst_n  in  1  reset, synchronous, active-low.
- mode  in  2  MCU layout: 0 = 4:2:0 (Y,Y,Y,Y,Cb,Cr), 1 = 4:2:2 (Y,Y,Cb,Cr), 2 = 4:4:4 (Y,Cb,Cr), 3 = grey (Y).
- din_valid  in  1  coefficient valid.
- din  in  DATA_W  signed coefficient, raster order within the block.
- din_ready  out  1  coefficient accepted when din_valid & din_ready.
- tbl_wr_en  in  1  table write strobe.
- tbl_wr_sel  in  1  0 = luma table, 1 = chroma table.
- tbl_wr_addr  in  6  raster index.
- tbl_wr_data  in  RECIP_W  reciprocal.
- dout_valid  out  1  output valid.
- dout  out  OUT_W  quantised coefficient, zig-zag order.
- dout_ready  in  1  downstream accept.
- dout_comp  out  2  0 = Y, 1 = Cb, 2 = Cr.
- dout_sob  out  1  zig-zag index 0 of a block.
- dout_eob  out  1  zig-zag index 63 of a block.
- dout_eomcu  out  1  index 63 of the last block of an MCU.

## Operation
- Input counters: coefficient index k (0..63), block index b within the MCU.
  - mode is latched when k=0, b=0 is accepted.
  - Component of block b comes from the latched mode sequence.
  - b wraps to 0 after the last block of the MCU.
- Tables: two 64 x RECIP_W register arrays with a registered read.
  - A write takes effect for reads issued on later edges; a same-cycle read of the written entry returns the old value.
  - Tables are not cleared by reset.
- Arithmetic:
  - p = din * {1'b0, recip}, signed, DATA_W+RECIP_W+1 bits.
  - q = p >>> RECIP_W (floor).
  - q saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Each bank has a state EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY, plus a stored component tag and eomcu flag.
  - The bank pointer is fixed at acceptance time, so in-flight pipeline writes always land in the correct bank.
- Write side:
  - din_ready = 1 when bank[wptr] is EMPTY or FILLING.
  - Accepting k=0 moves the bank to FILLING.
  - Accepting k=63 toggles wptr.
  - The bank becomes FULL on the edge that writes k=63.
- Read side:
  - bank[rptr] FULL -> DRAINING; reads follow the zig-zag LUT (0,1,8,16,9,2,3,10,...).
  - The output register loads when !dout_valid | dout_ready.
  - After index 63 transfers, the bank becomes EMPTY and rptr toggles.
  - A bank draining and refilling in the same cycle is legal; EMPTY wins before FILLING is evaluated.

## Timing
- Pipeline, for a coefficient accepted in cycle T:
  - T+1: table read and din register.
  - T+2: product register, then quantise/saturate and bank write at the end of T+2.
- Latency: k=63 accepted in cycle T with output idle -> dout_valid=1 with dout_sob in cycle T+4.
- Throughput: one coefficient per cycle sustained when dout_ready=1.
- dout and its tags hold stable while dout_valid & !dout_ready.
- Reset, effective at the edge sampling sys_rst_n=0:
  - din_ready=1 (from the next cycle).
  - dout_valid, dout, dout_comp, dout_sob, dout_eob, dout_eomcu all 0.
  - Banks EMPTY, pointers 0, k=b=0, pipeline flushed.
  - A partially accepted block is discarded.

## Configuration
- QUANT_ROUND_EN:
  - Defined: q = (p + 2^(RECIP_W-1)) >>> RECIP_W, i.e. round half up.
  - Undefined: floor, as in Operation.
  - Saturation applies in both cases.

## Test plan
All scenarios use default parameters except scenario 3.
1. Ordering: mode=3, luma all 0x8000, din=k for k=0..63 -> dout sequence 0,0,4,8,4,1,1,5,...; dout_sob on the first output, dout_eob/dout_eomcu on the 64th, first dout_valid 4 cycles after k=63.
2. Rounding: recip 0x8000.
   - din=-3 -> -2 without the macro, -1 with it.
   - din=5 -> 2 without, 3 with.
3. Saturation, OUT_W=8: recip 0xFFFF.
   - din=2047 -> 127.
   - din=-2048 -> -128.
4. 4:2:0 MCU: mode=0, luma 0x8000, chroma 0x4000, din=64 throughout -> six blocks.
   - dout_comp 0,0,0,0,1,2.
   - Y blocks output 32, chroma blocks output 16.
   - dout_eomcu only on the 384th output.
5. Backpressure: dout_ready=0, three blocks offered back-to-back -> din_ready=0 from the cycle after block 2 k=63 is accepted; raise dout_ready -> all 192 values emerge in order, none lost or duplicated.
6. Reset mid-block: reset after 30 coefficients -> next cycle dout_valid=0 and din_ready=1; the following 64 inputs form one Y block that produces correct output.
